// File: rtl/puzzle_uc.sv
// rtl/puzzle_uc.sv - game control unit for the 8x8 LED-matrix puzzle
// Debounces buttons into toggle pulses, sequences levels, enforces the move limit.
module puzzle_uc #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int MAX_JOGADAS  = 32,
  parameter int N_NIVEIS     = 5,
  parameter int WIN_HOLD     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [7:0] botoes,
  input  logic       nivel_concluido,
  output logic [7:0] botoes_pulso,
  output logic [2:0] nivel,
  output logic       rst_matriz,
  output logic [5:0] jogadas,
  output logic       ganhou,
  output logic       perdeu,
  output logic [2:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam int TW = $clog2(WIN_HOLD + 2);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LIMPA   = 3'd1,
    JOGA    = 3'd2,
    CONFERE = 3'd3,
    ESPERA  = 3'd4,
    GANHOU  = 3'd5,
    PERDEU  = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt [8];
  logic [7:0]      db, db_d, rise;
  logic [TW-1:0]   tmr;
  logic            first_joga;
  logic [2:0]      nivel_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      db   <= '0;
      db_d <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 8; i++) begin
        if (botoes[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
          db[i]  <= botoes[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = db & ~db_d;

  always_comb begin
    state_n = state;
    nivel_n = nivel;
    case (state)
      OCIOSO:  if (iniciar) state_n = LIMPA;
      LIMPA:   state_n = JOGA;
      JOGA: begin
        // the flag may still be high from the previous level on the first cycle
        if (!first_joga && nivel_concluido) state_n = ESPERA;
        else if (jogadas == 6'(MAX_JOGADAS)) state_n = CONFERE;
      end
      CONFERE: begin
        if (nivel_concluido) state_n = ESPERA;
        else if (tmr == TW'(1)) state_n = PERDEU;
      end
      ESPERA: begin
        if (tmr == TW'(WIN_HOLD - 1)) begin
          if (nivel == 3'(N_NIVEIS - 1)) begin
            state_n = GANHOU;
          end else begin
            nivel_n = nivel + 3'd1;
            state_n = LIMPA;
          end
        end
      end
      GANHOU: begin
        if (iniciar) begin
          nivel_n = '0;
          state_n = LIMPA;
        end
      end
      PERDEU:  if (iniciar) state_n = LIMPA;
      default: state_n = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= OCIOSO;
      nivel        <= '0;
      jogadas      <= '0;
      botoes_pulso <= '0;
      ganhou       <= 1'b0;
      perdeu       <= 1'b0;
      rst_matriz   <= 1'b1;
      tmr          <= '0;
      first_joga   <= 1'b0;
    end else begin
      state        <= state_n;
      nivel        <= nivel_n;
      tmr          <= (state_n != state) ? '0 : tmr + 1'b1;
      first_joga   <= (state == LIMPA);
      botoes_pulso <= (state == JOGA) ? rise : '0;
      if (state_n == LIMPA)
        jogadas <= '0;
      else if (state == JOGA && rise != '0 && jogadas != 6'(MAX_JOGADAS))
        jogadas <= jogadas + 6'd1;
      rst_matriz   <= (state_n == OCIOSO) || (state_n == LIMPA);
      ganhou       <= (state_n == GANHOU);
      perdeu       <= (state_n == PERDEU);
    end
  end

  assign db_estado = state;

endmodule

// File: tb/tb_puzzle_uc.sv
// tb/tb_puzzle_uc.sv - self-checking bench for puzzle_uc
// Random and directed stimulus against a cycle-level behavioural game model.
module tb_puzzle_uc;
  localparam int D = 4, MAXJ = 3, NN = 5, WH = 8;

  logic       clk = 1'b0, rst_n = 1'b0, iniciar = 1'b0;
  logic [7:0] botoes = 8'h00;
  logic       nivel_concluido;
  logic [7:0] botoes_pulso;
  logic [2:0] nivel, db_estado;
  logic       rst_matriz, ganhou, perdeu;
  logic [5:0] jogadas;

  always #5 clk = ~clk;

  puzzle_uc #(.DEBOUNCE_CYC(D), .MAX_JOGADAS(MAXJ), .N_NIVEIS(NN), .WIN_HOLD(WH)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .botoes(botoes),
    .nivel_concluido(nivel_concluido), .botoes_pulso(botoes_pulso), .nivel(nivel),
    .rst_matriz(rst_matriz), .jogadas(jogadas), .ganhou(ganhou), .perdeu(perdeu),
    .db_estado(db_estado)
  );

  int compared = 0, mismatched = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Matrix stand-in: level done once enough move-cycles have been seen.
  int   target = 0, mcnt = 0;
  logic mdone = 1'b0, inject = 1'b0;
  always @(posedge clk) begin
    if (rst_matriz === 1'b1) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else begin
      if (botoes_pulso != 8'h00) mcnt <= mcnt + 1;
      mdone <= (target != 0 && mcnt >= target);
    end
  end
  assign nivel_concluido = mdone | inject;

  // Reference: debounce as "last D samples all opposite", game as phases with age.
  int         ph = 0, age = 0, m_niv = 0, m_jog = 0;
  logic [7:0] m_pulse = 8'h00, mdb = 8'h00, pend = 8'h00;
  logic       m_rstm = 1'b1, m_gan = 1'b0, m_per = 1'b0;
  logic [D-1:0] hist [8];

  always @(posedge clk) begin : model
    int         ph_n;
    logic [7:0] fwd;
    if (!rst_n) begin
      ph = 0; age = 0; m_niv = 0; m_jog = 0;
      m_pulse = 8'h00; mdb = 8'h00; pend = 8'h00;
      m_rstm = 1'b1; m_gan = 1'b0; m_per = 1'b0;
      for (int i = 0; i < 8; i++) hist[i] = '0;
    end else begin
      fwd  = (ph == 2) ? pend : 8'h00;
      ph_n = ph;
      case (ph)
        0: if (iniciar) ph_n = 1;
        1: ph_n = 2;
        2: if (age > 0 && nivel_concluido) ph_n = 4;
           else if (m_jog == MAXJ) ph_n = 3;
        3: if (nivel_concluido) ph_n = 4;
           else if (age == 1) ph_n = 6;
        4: if (age == WH - 1) begin
             if (m_niv == NN - 1) ph_n = 5;
             else begin m_niv++; ph_n = 1; end
           end
        5: if (iniciar) begin m_niv = 0; ph_n = 1; end
        6: if (iniciar) ph_n = 1;
        default: ph_n = 0;
      endcase
      if (ph_n == 1) m_jog = 0;
      else if (fwd != 8'h00 && m_jog < MAXJ) m_jog++;
      m_pulse = fwd;
      pend = 8'h00;
      for (int i = 0; i < 8; i++) begin
        hist[i] = {hist[i][D-2:0], botoes[i]};
        if (hist[i] == {D{~mdb[i]}}) begin
          mdb[i]  = ~mdb[i];
          pend[i] = mdb[i];
        end
      end
      age    = (ph_n == ph) ? age + 1 : 0;
      ph     = ph_n;
      m_rstm = (ph <= 1);
      m_gan  = (ph == 5);
      m_per  = (ph == 6);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state", db_estado, ph);
      check("nivel", nivel, m_niv);
      check("jogadas", jogadas, m_jog);
      check("botoes_pulso", botoes_pulso, m_pulse);
      check("rst_matriz", rst_matriz, m_rstm);
      check("ganhou", ganhou, m_gan);
      check("perdeu", perdeu, m_per);
    end
  end

  task automatic wait_state(input logic [2:0] code, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (db_estado == code) break;
    end
    check("wait_state", db_estado, code);
  endtask

  task automatic press(input logic [7:0] mask);
    botoes = mask;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (botoes_pulso != 8'h00) break;
    end
    botoes = 8'h00;
  endtask

  task automatic gap();
    repeat (D + 2) @(negedge clk);
  endtask

  initial begin
    int   n;
    logic seen;
    @(posedge clk); cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", db_estado, 0);
    check("rst_nivel", nivel, 0);
    check("rst_rstm", rst_matriz, 1);
    check("rst_jog", jogadas, 0);
    rst_n = 1'b1; iniciar = 1'b1;
    @(negedge clk); iniciar = 1'b0;
    check("limpa_state", db_estado, 1);
    check("limpa_rstm", rst_matriz, 1);
    @(negedge clk);
    check("joga_state", db_estado, 2);
    check("joga_rstm", rst_matriz, 0);

    // short glitch, then a real press with exact latency
    seen = 1'b0;
    botoes[3] = 1'b1;
    repeat (3) @(negedge clk);
    botoes[3] = 1'b0;
    repeat (8) begin @(negedge clk); if (botoes_pulso != 0) seen = 1'b1; end
    check("glitch_nopulse", seen, 0);
    botoes[3] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (botoes_pulso != 0) break;
    end
    check("pulse_latency", n, D + 1);
    check("pulse_value", botoes_pulso, 8'h08);
    @(negedge clk);
    check("pulse_width", botoes_pulso, 0);
    check("pulse_jog", jogadas, 1);
    repeat (5) @(negedge clk);
    botoes = 8'h00; seen = 1'b0;
    repeat (10) begin @(negedge clk); if (botoes_pulso != 0) seen = 1'b1; end
    check("release_nopulse", seen, 0);

    // play through all levels
    target = 1;
    for (int l = 0; l < NN; l++) begin
      if (l > 0) press(8'($urandom_range(1, 255)));
      wait_state(4, 40);
      check("espera_nivel", nivel, l);
      n = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (db_estado != 4) break;
        n++;
      end
      check("espera_len", n, WH);
      if (l < NN - 1) begin
        check("after_espera", db_estado, 1);
        check("after_espera_nivel", nivel, l + 1);
        @(negedge clk);
        check("back_joga", db_estado, 2);
      end else begin
        check("won_state", db_estado, 5);
      end
    end
    check("ganhou_flag", ganhou, 1);
    check("ganhou_nivel", nivel, NN - 1);

    // exhaust the move limit
    iniciar = 1'b1; @(negedge clk); iniciar = 1'b0;
    check("restart_nivel", nivel, 0);
    target = 0;
    @(negedge clk);
    press(8'h01); gap(); press(8'h12); gap(); press(8'h80);
    @(negedge clk); check("confere_a", db_estado, 3);
    @(negedge clk); check("confere_b", db_estado, 3);
    @(negedge clk); check("perdeu_state", db_estado, 6);
    check("perdeu_flag", perdeu, 1);
    check("perdeu_nivel", nivel, 0);
    iniciar = 1'b1; @(negedge clk); iniciar = 1'b0;
    check("retry_state", db_estado, 1);
    check("retry_jog", jogadas, 0);
    check("retry_perdeu", perdeu, 0);

    // limit press completes the level two cycles later
    @(negedge clk);
    target = 3;
    press(8'h04); gap(); press(8'h04); gap(); press(8'h04);
    @(negedge clk); check("late_confere_a", db_estado, 3);
    @(negedge clk); check("late_confere_b", db_estado, 3);
    @(negedge clk); check("late_win", db_estado, 4);
    wait_state(2, 20);
    check("late_nivel", nivel, 1);

    // completion and limit in the same JOGA cycle
    target = 0;
    press(8'h20); gap(); press(8'h20); gap(); press(8'h20);
    inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    check("same_cycle", db_estado, 4);

    // stale completion flag on the first JOGA cycle is ignored
    wait_state(1, 20);
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    check("stale_guard", db_estado, 2);
    check("stale_nivel", nivel, 2);

    // reset mid-ESPERA with a button held
    target = 1;
    botoes = 8'h01;
    wait_state(4, 30);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("mid_rst_state", db_estado, 0);
    check("mid_rst_nivel", nivel, 0);
    check("mid_rst_jog", jogadas, 0);
    check("mid_rst_pulse", botoes_pulso, 0);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (botoes_pulso != 0) seen = 1'b1; end
    iniciar = 1'b1; @(negedge clk); iniciar = 1'b0;
    repeat (12) begin @(negedge clk); if (botoes_pulso != 0) seen = 1'b1; end
    check("held_nopulse", seen, 0);
    botoes = 8'h00;

    // random play
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) botoes[b] = ~botoes[b];
      iniciar = ($urandom_range(0, 25) == 0);
      if ($urandom_range(0, 60) == 0) target = $urandom_range(0, 4);
      rst_n = ($urandom_range(0, 500) != 0);
    end
    rst_n = 1'b1; iniciar = 1'b0; botoes = 8'h00;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
